// File: rtl/hmac_pkg.sv
// Shared constants and types for the HMAC-384 wrapper message path.
package hmac_pkg;

  localparam int         HMAC_BLOCK_BYTES     = 128;
  localparam int         HMAC_LEN_FIELD_BYTES = 16;
  localparam logic [7:0] HMAC_PAD_BYTE        = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_PAD   = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_TAG   = 3'd5
  } feeder_state_e;

endpackage

// File: rtl/hmac_msg_feeder_pad_mask.sv
// Padding geometry for the block that carries (or follows) the last message word.
// With last=1, the data ends at byte 4*wptr+in_bytes. Bytes before that are kept,
// 0x80 goes at that position if it is inside the block, and the length field fits
// only if the 0x80 lands at or before byte 111. With last=0, the block holds no
// message data, so nothing is kept and the length field always fits.
module hmac_pad_mask
  import hmac_pkg::*;
(
  input  logic [4:0]   wptr,
  input  logic [2:0]   in_bytes,
  input  logic         last,
  output logic [127:0] keep,
  output logic [6:0]   pad_pos,
  output logic         pad_in_blk,
  output logic         fits_len
);

  logic [7:0] data_end;

  // Derive the keep mask, the 0x80 position and whether the length still fits.
  always_comb begin
    data_end = {1'b0, wptr, 2'b00} + {5'b0, in_bytes};
    keep     = '0;
    for (int b = 0; b < HMAC_BLOCK_BYTES; b++) begin
      keep[b] = last && (8'(b) < data_end);
    end
    pad_pos    = data_end[6:0];
    pad_in_blk = last && !data_end[7];
    fits_len   = !last ||
                 (data_end < 8'(HMAC_BLOCK_BYTES - HMAC_LEN_FIELD_BYTES));
  end

endmodule

// File: rtl/hmac_msg_feeder.sv
// Packs a 32-bit big-endian word stream into 1024-bit SHA-384 blocks, applies the
// 0x80 / zero / 128-bit length padding and hands each block to the HMAC core with
// an init or next command, pacing itself on core_ready.
module hmac_msg_feeder
  import hmac_pkg::*;
#(
  parameter int LEN_OFFSET = 1024,
  parameter int LEN_W      = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  input  logic          in_last,
  input  logic [2:0]    in_bytes,
  output logic [1023:0] core_block,
  output logic          core_init,
  output logic          core_next,
  input  logic          core_ready,
  input  logic          core_tag_valid,
  output logic          busy,
  output logic          done
);

  feeder_state_e state;
  logic [1023:0] blk;
  logic [1023:0] pad_block;
  logic [127:0]  len_field;
  logic [LEN_W-1:0] cnt;
  logic [4:0]    wptr;
  logic [2:0]    last_bytes;
  logic          first_blk;
  logic          final_blk;
  logic          pad_pend;
  logic          pad_defer;
  logic          wait_cnt;
  logic          tag_q;
  logic          tag_pend;
  logic          tag_rise;

  logic [127:0]  keep;
  logic [6:0]    pad_pos;
  logic          pad_in_blk;
  logic          fits_len;

  // During the overflow block (pad_pend) there is no message data left in it.
  hmac_pad_mask u_pad_mask (
    .wptr       (wptr),
    .in_bytes   (last_bytes),
    .last       (!pad_pend),
    .keep       (keep),
    .pad_pos    (pad_pos),
    .pad_in_blk (pad_in_blk),
    .fits_len   (fits_len)
  );

  assign core_block = blk;
  assign busy       = (state != ST_IDLE);
  assign in_ready   = (state == ST_FILL);
  assign tag_rise   = core_tag_valid && !tag_q;

  // Build the padded version of the current block, including the length field when it fits.
  always_comb begin
    pad_block = '0;
    len_field = '0;
    len_field[LEN_W-1:0] = cnt + LEN_W'(LEN_OFFSET);
    for (int b = 0; b < HMAC_BLOCK_BYTES; b++) begin
      if (keep[b]) begin
        pad_block[1023-8*b -: 8] = blk[1023-8*b -: 8];
      end else if (pad_in_blk && (pad_pos == 7'(b))) begin
        pad_block[1023-8*b -: 8] = HMAC_PAD_BYTE;
      end
    end
    if (pad_pend && pad_defer) begin
      pad_block[1023 -: 8] = HMAC_PAD_BYTE;
    end
    if (fits_len) begin
      pad_block[127:0] = len_field;
    end
  end

  // Main sequencer: word capture, padding, command issue, core pacing and tag wait.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      blk        <= '0;
      cnt        <= '0;
      wptr       <= '0;
      last_bytes <= '0;
      first_blk  <= 1'b1;
      final_blk  <= 1'b0;
      pad_pend   <= 1'b0;
      pad_defer  <= 1'b0;
      wait_cnt   <= 1'b0;
      tag_q      <= 1'b0;
      tag_pend   <= 1'b0;
      core_init  <= 1'b0;
      core_next  <= 1'b0;
      done       <= 1'b0;
    end else begin
      core_init <= 1'b0;
      core_next <= 1'b0;
      done      <= 1'b0;
      tag_q     <= core_tag_valid;
      case (state)
        ST_IDLE: begin
          first_blk <= 1'b1;
          cnt       <= '0;
          if (start) begin
            state     <= ST_FILL;
            blk       <= '0;
            wptr      <= '0;
            final_blk <= 1'b0;
            pad_pend  <= 1'b0;
            pad_defer <= 1'b0;
            tag_pend  <= 1'b0;
          end
        end
        ST_FILL: begin
          if (in_valid) begin
            blk[1023-32*int'(wptr) -: 32] <= in_data;
            cnt <= cnt + LEN_W'({in_bytes, 3'b000});
            if (in_last) begin
              last_bytes <= in_bytes;
              state      <= ST_PAD;
            end else if (wptr == 5'd31) begin
              final_blk <= 1'b0;
              state     <= ST_ISSUE;
            end else begin
              wptr <= wptr + 5'd1;
            end
          end
        end
        ST_PAD: begin
          blk       <= pad_block;
          final_blk <= fits_len;
          pad_pend  <= !fits_len;
          pad_defer <= pad_pend ? 1'b0 : !pad_in_blk;
          state     <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (core_ready) begin
            core_init <= first_blk;
            core_next <= !first_blk;
            first_blk <= 1'b0;
            wait_cnt  <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (final_blk && tag_rise) begin
            tag_pend <= 1'b1;
          end
          if (!wait_cnt) begin
            wait_cnt <= 1'b1;
          end else if (core_ready) begin
            if (final_blk) begin
              state <= ST_TAG;
            end else if (pad_pend) begin
              state <= ST_PAD;
            end else begin
              state <= ST_FILL;
              wptr  <= '0;
              blk   <= '0;
            end
          end
        end
        ST_TAG: begin
          if (tag_pend || tag_rise) begin
            done     <= 1'b1;
            tag_pend <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hmac_msg_feeder.sv
// Self-checking bench for hmac_msg_feeder: directed padding cases, core stall,
// reset mid-message and randomized messages against a byte-level padding model.
module tb_hmac_msg_feeder;

  typedef logic [7:0]    bq_t [$];
  typedef logic [1023:0] blk_q_t [$];

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          in_last;
  logic [2:0]    in_bytes;
  logic [1023:0] core_block;
  logic          core_init;
  logic          core_next;
  logic          core_ready;
  logic          core_tag_valid;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_err = 0;
  blk_q_t cap_q;
  int     kind_q [$];
  int     stall_cycles = 2;
  int     stall_obs = 0;
  int     stall_viol = 0;

  hmac_msg_feeder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .in_bytes       (in_bytes),
    .core_block     (core_block),
    .core_init      (core_init),
    .core_next      (core_next),
    .core_ready     (core_ready),
    .core_tag_valid (core_tag_valid),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Core model: records every command with its block, then holds ready low for a while.
  initial begin
    int hold;
    hold = 0;
    core_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        core_ready = 1'b1;
        hold = 0;
      end else if (core_init || core_next) begin
        cap_q.push_back(core_block);
        kind_q.push_back(int'({core_next, core_init}));
        core_ready = 1'b0;
        hold = stall_cycles;
      end else if (!core_ready) begin
        if (hold > 0) hold--;
        else core_ready = 1'b1;
      end
    end
  end

  // While the core is busy the feeder must hold its block and refuse input.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && busy && !core_ready && !(core_init || core_next) && cap_q.size() > 0) begin
        stall_obs++;
        if (in_ready || core_block !== cap_q[cap_q.size()-1]) stall_viol++;
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: message bytes + 0x80 + zeros up to 112 mod 128 + 128-bit bit length (+1024).
  function automatic void build_expected(input bq_t msg, output blk_q_t blks);
    bq_t m;
    logic [63:0]   bits;
    logic [127:0]  len;
    logic [1023:0] b;
    m = msg;
    m.push_back(8'h80);
    while ((m.size() % 128) != 112) m.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8 + 64'd1024;
    len  = {64'h0, bits};
    for (int i = 15; i >= 0; i--) m.push_back(len[8*i +: 8]);
    blks.delete();
    for (int k = 0; k < m.size() / 128; k++) begin
      b = '0;
      for (int j = 0; j < 128; j++) b[1023-8*j -: 8] = m[128*k+j];
      blks.push_back(b);
    end
  endfunction

  function automatic logic [1023:0] cap_at(input int i);
    if (i < cap_q.size()) return cap_q[i];
    return {1024{1'bx}};
  endfunction

  task automatic send_word(input logic [31:0] d, input logic lst, input logic [2:0] nb,
                           input string name);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = lst;
    in_bytes = nb;
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL %s word accept timeout: in_ready=%b required 1", name, in_ready);
    end else begin
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_msg(input bq_t msg, input bit extra_empty, input bit start_mid,
                         input string name, output int base);
    blk_q_t exp;
    int n, nw, leak, dones, guard, gk, wk;
    logic [1023:0] got, want;
    build_expected(msg, exp);
    base = cap_q.size();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL %s busy after start: got %b want 1", name, busy);
    end
    n  = msg.size();
    nw = (n + 3) / 4;
    if (n == 0) begin
      send_word($urandom, 1'b1, 3'd0, name);
    end else begin
      for (int w = 0; w < nw; w++) begin
        logic [31:0] d;
        int nb;
        logic lst;
        d  = $urandom;
        nb = (n - 4*w >= 4) ? 4 : n - 4*w;
        for (int j = 0; j < nb; j++) d[31-8*j -: 8] = msg[4*w+j];
        lst = (w == nw - 1) && !extra_empty;
        send_word(d, lst, 3'(nb), name);
        if (start_mid && w == 0) begin
          @(negedge clk);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
      if (extra_empty) send_word($urandom, 1'b1, 3'd0, name);
    end
    leak  = 0;
    guard = 0;
    while ((cap_q.size() - base < exp.size() || !core_ready) && guard < 1000) begin
      @(negedge clk);
      if (in_ready) leak++;
      guard++;
    end
    if (guard >= 1000) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL %s command timeout: got %0d blocks want %0d", name,
               cap_q.size() - base, exp.size());
    end
    repeat (3) begin
      @(negedge clk);
      if (in_ready) leak++;
    end
    core_tag_valid = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
      if (in_ready) leak++;
    end
    core_tag_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (cap_q.size() - base != exp.size()) begin
      n_err++;
      $display("[TB] FAIL %s block count: got %0d want %0d", name, cap_q.size() - base, exp.size());
    end
    for (int k = 0; k < exp.size(); k++) begin
      got  = cap_at(base + k);
      want = exp[k];
      n_vec++;
      if (got !== want) begin
        wk = 0;
        for (int q = 31; q >= 0; q--) if (got[1023-32*q -: 32] !== want[1023-32*q -: 32]) wk = q;
        n_err++;
        $display("[TB] FAIL %s block%0d word%0d: got %h want %h", name, k, wk,
                 got[1023-32*wk -: 32], want[1023-32*wk -: 32]);
      end
      gk = (base + k < kind_q.size()) ? kind_q[base + k] : -1;
      n_vec++;
      if (gk != ((k == 0) ? 1 : 2)) begin
        n_err++;
        $display("[TB] FAIL %s block%0d command (1=init 2=next): got %0d want %0d", name, k, gk,
                 (k == 0) ? 1 : 2);
      end
    end
    n_vec++;
    if (leak != 0) begin
      n_err++;
      $display("[TB] FAIL %s in_ready after last word: got %0d cycles want 0", name, leak);
    end
    n_vec++;
    if (dones != 1) begin
      n_err++;
      $display("[TB] FAIL %s done pulses: got %0d want 1", name, dones);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL %s busy after done: got %b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    int bad;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, in_ready, core_init, core_next, done} !== 5'b0) begin
      n_err++;
      $display("[TB] FAIL reset outputs {busy,in_ready,init,next,done}: got %b want 00000",
               {busy, in_ready, core_init, core_next, done});
    end
    n_vec++;
    if (core_block !== '0) begin
      n_err++;
      $display("[TB] FAIL reset core_block: got nonzero %h want 0", core_block[1023:992]);
    end
    reset_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'hdeadbeef;
    in_last  = 1'b1;
    in_bytes = 3'd4;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (in_ready || busy) bad++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("[TB] FAIL idle input accept: got %0d ready/busy cycles want 0", bad);
    end
  endtask

  task automatic test_abc();
    bq_t msg;
    int base;
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg(msg, 1'b0, 1'b0, "abc", base);
    n_vec++;
    if (cap_at(base) !== {32'h61626380, 928'h0, 32'h0, 32'h418}) begin
      n_err++;
      $display("[TB] FAIL abc literal: got w0=%h w31=%h want 61626380 00000418",
               cap_at(base) >> 992, cap_at(base) & 1024'hffffffff);
    end
  endtask

  task automatic test_112();
    bq_t msg;
    int base;
    logic [1023:0] b;
    for (int i = 0; i < 112; i++) msg.push_back(8'($urandom));
    run_msg(msg, 1'b0, 1'b0, "len112", base);
    b = cap_at(base);
    n_vec++;
    if (b[1023-32*28 -: 32] !== 32'h80000000 || b[95:0] !== 96'h0) begin
      n_err++;
      $display("[TB] FAIL len112 block0 tail: got w28=%h want 80000000", b[1023-32*28 -: 32]);
    end
    n_vec++;
    if (cap_at(base + 1) !== {992'h0, 32'h780}) begin
      n_err++;
      $display("[TB] FAIL len112 block1 literal: got w31=%h want 00000780", cap_at(base + 1) & 1024'hffffffff);
    end
  endtask

  task automatic test_128();
    bq_t msg;
    int base;
    for (int i = 0; i < 128; i++) msg.push_back(8'($urandom));
    run_msg(msg, 1'b0, 1'b0, "len128", base);
    n_vec++;
    if (cap_at(base + 1) !== {32'h80000000, 960'h0, 32'h800}) begin
      n_err++;
      $display("[TB] FAIL len128 block1 literal: got w0=%h want 80000000", cap_at(base + 1) >> 992);
    end
  endtask

  task automatic test_empty();
    bq_t msg;
    int base;
    run_msg(msg, 1'b0, 1'b0, "empty", base);
    n_vec++;
    if (cap_at(base) !== {32'h80000000, 960'h0, 32'h400}) begin
      n_err++;
      $display("[TB] FAIL empty literal: got w0=%h want 80000000", cap_at(base) >> 992);
    end
  endtask

  task automatic test_stall();
    bq_t msg;
    int base, obs0, viol0;
    for (int i = 0; i < 200; i++) msg.push_back(8'($urandom));
    stall_cycles = 50;
    obs0  = stall_obs;
    viol0 = stall_viol;
    run_msg(msg, 1'b0, 1'b0, "stall", base);
    stall_cycles = 2;
    n_vec++;
    if (stall_viol - viol0 != 0) begin
      n_err++;
      $display("[TB] FAIL stall hold: got %0d unstable cycles want 0", stall_viol - viol0);
    end
    n_vec++;
    if (stall_obs - obs0 < 90) begin
      n_err++;
      $display("[TB] FAIL stall length: got %0d stalled cycles want >= 90", stall_obs - obs0);
    end
  endtask

  task automatic test_reset_mid();
    bq_t msg;
    int base, stale;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int w = 0; w < 10; w++) send_word(32'h11111111 * (w + 1), 1'b0, 3'd4, "rstmid");
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, in_ready, core_init, core_next, done} !== 5'b0) begin
      n_err++;
      $display("[TB] FAIL reset mid-fill outputs: got %b want 00000",
               {busy, in_ready, core_init, core_next, done});
    end
    n_vec++;
    if (core_block !== '0) begin
      n_err++;
      $display("[TB] FAIL reset mid-fill core_block: got w0=%h want 0", core_block[1023:992]);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (core_init || core_next || done || busy) stale++;
    end
    n_vec++;
    if (stale != 0) begin
      n_err++;
      $display("[TB] FAIL stale pulses after reset: got %0d want 0", stale);
    end
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg(msg, 1'b0, 1'b1, "abc_after_reset", base);
    n_vec++;
    if (cap_at(base) !== {32'h61626380, 928'h0, 32'h0, 32'h418}) begin
      n_err++;
      $display("[TB] FAIL abc_after_reset literal: got w0=%h want 61626380", cap_at(base) >> 992);
    end
  endtask

  task automatic test_random();
    int edges [10] = '{1, 4, 108, 111, 112, 113, 124, 127, 240, 256};
    for (int i = 0; i < 16; i++) begin
      bq_t msg;
      int n, base;
      bit ee;
      n = (i < 10) ? edges[i] : $urandom_range(0, 300);
      for (int j = 0; j < n; j++) msg.push_back(8'($urandom));
      ee = (n > 0 && (n % 4) == 0) ? bit'($urandom_range(0, 1)) : 1'b0;
      stall_cycles = $urandom_range(0, 5);
      run_msg(msg, ee, 1'b0, $sformatf("rand%0d_len%0d", i, n), base);
    end
    stall_cycles = 2;
  endtask

  initial begin
    reset_n        = 1'b0;
    start          = 1'b0;
    in_valid       = 1'b0;
    in_data        = '0;
    in_last        = 1'b0;
    in_bytes       = '0;
    core_tag_valid = 1'b0;
    test_reset();
    test_abc();
    test_112();
    test_128();
    test_empty();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
